// File: rtl/mfp_ahb_arbiter.sv
// Two-master AHB-Lite arbiter for the MIPS core (M0) and DMA/loader (M1).
// A master that issues an address while it does not own the bus has the
// request captured into a hold register and is stalled until that transfer
// has been replayed on the shared bus and its data phase has completed.
module mfp_ahb_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP,

  output logic        GRANT
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  owner_e            owner_q, owner_d, other;
  owner_e            data_owner_q;
  logic              data_valid_q;
  logic [2:0]        hold_cnt_q, hold_cnt_d;

  logic [1:0]        pend_q;
  logic [1:0][31:0]  hold_addr_q;
  logic [1:0][1:0]   hold_trans_q;
  logic [1:0]        hold_write_q;
  logic [1:0][2:0]   hold_size_q;

  logic [1:0][31:0]  live_addr, eff_addr;
  logic [1:0][1:0]   live_trans, eff_trans;
  logic [1:0]        live_write, eff_write;
  logic [1:0][2:0]   live_size, eff_size;

  logic [1:0]        req, live_req, hready, acc_own, capture;
  logic              switch_c, addr_accept;
  logic [1:0]        bus_trans;

  assign live_addr  = {M1_HADDR,   M0_HADDR};
  assign live_trans = {M1_HTRANS,  M0_HTRANS};
  assign live_write = {M1_HWRITE,  M0_HWRITE};
  assign live_size  = {M1_HSIZE,   M0_HSIZE};
  assign live_req   = {M1_HTRANS[1], M0_HTRANS[1]};

  // Effective request per master: replay the held request while it is pending.
  always_comb begin
    eff_addr  = '0;
    eff_trans = '0;
    eff_write = '0;
    eff_size  = '0;
    req       = '0;
    for (int unsigned m = 0; m < 2; m++) begin
      eff_addr[m]  = pend_q[m] ? hold_addr_q[m]  : live_addr[m];
      eff_trans[m] = pend_q[m] ? hold_trans_q[m] : live_trans[m];
      eff_write[m] = pend_q[m] ? hold_write_q[m] : live_write[m];
      eff_size[m]  = pend_q[m] ? hold_size_q[m]  : live_size[m];
      req[m]       = eff_trans[m][1];
    end
  end

  assign other = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;

  // Hand over only between bursts; the owner keeps the bus while it still
  // requests, until it has used up MAX_HOLD NONSEQ transfers under contention.
  assign switch_c = S_HREADY
                    && (eff_trans[owner_q] != HTRANS_SEQ)
                    && req[other]
                    && (!req[owner_q] || (32'(hold_cnt_q) >= MAX_HOLD));

  assign bus_trans   = switch_c ? HTRANS_IDLE : eff_trans[owner_q];
  assign addr_accept = S_HREADY && bus_trans[1];

  assign acc_own[0] = addr_accept && (owner_q == OWN_M0);
  assign acc_own[1] = addr_accept && (owner_q == OWN_M1);

  assign hready[0] = (data_valid_q && data_owner_q == OWN_M0) ? S_HREADY : ~pend_q[0];
  assign hready[1] = (data_valid_q && data_owner_q == OWN_M1) ? S_HREADY : ~pend_q[1];

  // A master that sees HREADY=1 believes its address was taken; if the bus did
  // not actually take it this edge, it must be parked in the hold register.
  assign capture = live_req & ~pend_q & hready & ~acc_own;

  // Arbitration next-state: owner hand-over and saturating hold counter.
  always_comb begin
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    if (switch_c) begin
      owner_d    = other;
      hold_cnt_d = '0;
    end else if (S_HREADY) begin
      if (!req[other]) begin
        hold_cnt_d = '0;
      end else if (addr_accept && bus_trans == HTRANS_NONSEQ && hold_cnt_q != 3'd7) begin
        hold_cnt_d = hold_cnt_q + 3'd1;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q    <= OWN_M0;
      hold_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Data-phase tracking plus per-master hold registers and pend flags.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_owner_q <= OWN_M0;
      data_valid_q <= 1'b0;
      pend_q       <= '0;
      hold_addr_q  <= '0;
      hold_trans_q <= '0;
      hold_write_q <= '0;
      hold_size_q  <= '0;
    end else begin
      if (S_HREADY) begin
        data_valid_q <= addr_accept;
        if (addr_accept) begin
          data_owner_q <= owner_q;
        end
      end
      for (int unsigned m = 0; m < 2; m++) begin
        if (capture[m]) begin
          hold_addr_q[m]  <= live_addr[m];
          hold_trans_q[m] <= live_trans[m];
          hold_write_q[m] <= live_write[m];
          hold_size_q[m]  <= live_size[m];
          pend_q[m]       <= 1'b1;
        end else if (acc_own[m]) begin
          pend_q[m]       <= 1'b0;
        end
      end
    end
  end

  assign S_HADDR   = eff_addr[owner_q];
  assign S_HTRANS  = bus_trans;
  assign S_HWRITE  = eff_write[owner_q];
  assign S_HSIZE   = eff_size[owner_q];
  assign S_HWDATA  = (data_owner_q == OWN_M1) ? M1_HWDATA : M0_HWDATA;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRESP  = data_valid_q && (data_owner_q == OWN_M0) && S_HRESP;
  assign M1_HRESP  = data_valid_q && (data_owner_q == OWN_M1) && S_HRESP;

  assign GRANT     = (owner_q == OWN_M1);

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// Bench for mfp_ahb_arbiter: directed two-master scenarios; a monitor checks
// every address accepted on the shared bus and every write data phase against
// queues of hand-computed expected transfers.
module tb_mfp_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        HCLK, HRESETn;
  logic [31:0] M0_HADDR, M0_HWDATA, M0_HRDATA;
  logic [1:0]  M0_HTRANS;
  logic        M0_HWRITE, M0_HREADY, M0_HRESP;
  logic [2:0]  M0_HSIZE;
  logic [31:0] M1_HADDR, M1_HWDATA, M1_HRDATA;
  logic [1:0]  M1_HTRANS;
  logic        M1_HWRITE, M1_HREADY, M1_HRESP;
  logic [2:0]  M1_HSIZE;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HREADY, S_HRESP;
  logic [2:0]  S_HSIZE;
  logic        GRANT;

  typedef struct {
    logic [31:0] addr;
    logic        grant;
    logic        write;
  } xfer_t;

  xfer_t       addr_q[$];
  logic [31:0] wdata_q[$];
  int          checks;
  int          errors;
  logic        dp_valid;
  logic        dp_write;

  mfp_ahb_arbiter #(.MAX_HOLD(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
    .M0_HSIZE(M0_HSIZE), .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA),
    .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
    .M1_HSIZE(M1_HSIZE), .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA),
    .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA),
    .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
    .GRANT(GRANT)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_addr(input logic [31:0] a, input logic g, input logic w);
    xfer_t x;
    x.addr = a; x.grant = g; x.write = w;
    addr_q.push_back(x);
  endtask

  task automatic exp_data(input logic [31:0] d);
    wdata_q.push_back(d);
  endtask

  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HSIZE = 3'b010; M0_HWDATA = d;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
    M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HSIZE = 3'b010; M1_HWDATA = d;
  endtask

  task automatic to_mid();
    @(negedge HCLK);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  // Bus monitor: pops expected transfers as the shared bus accepts addresses
  // and expected write data as write data phases complete.
  task automatic run_monitor();
    xfer_t x;
    logic [31:0] d;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dp_valid = 1'b0;
      end else begin
        if (dp_valid && S_HREADY) begin
          if (dp_write) begin
            if (wdata_q.size() == 0) begin
              chk("unexpected_wdata", S_HWDATA, 32'hFFFF_FFFF ^ S_HWDATA);
            end else begin
              d = wdata_q.pop_front();
              chk("sb_wdata", S_HWDATA, d);
            end
          end
          dp_valid = 1'b0;
        end
        if (S_HREADY && S_HTRANS[1]) begin
          if (addr_q.size() == 0) begin
            chk("unexpected_addr", S_HADDR, ~S_HADDR);
          end else begin
            x = addr_q.pop_front();
            chk("sb_addr",  S_HADDR,        x.addr);
            chk("sb_grant", 32'(GRANT),     32'(x.grant));
            chk("sb_write", 32'(S_HWRITE),  32'(x.write));
          end
          dp_valid = 1'b1;
          dp_write = S_HWRITE;
        end
      end
    end
  endtask

  initial begin
    HCLK = 1'b0; HRESETn = 1'b0;
    checks = 0; errors = 0; dp_valid = 1'b0; dp_write = 1'b0;
    drv0(IDLE, '0, 1'b0, '0);
    drv1(IDLE, '0, 1'b0, '0);
    S_HREADY = 1'b1; S_HRESP = 1'b0; S_HRDATA = 32'h1234_5678;
    fork
      run_monitor();
    join_none

    // Reset state
    next();
    to_mid();
    chk("rst_htrans",  32'(S_HTRANS),  32'd0);
    chk("rst_m0_rdy",  32'(M0_HREADY), 32'd1);
    chk("rst_m1_rdy",  32'(M1_HREADY), 32'd1);
    chk("rst_grant",   32'(GRANT),     32'd0);
    chk("rst_m0_resp", 32'(M0_HRESP),  32'd0);
    next();
    HRESETn = 1'b1;

    // M0 single read alone
    exp_addr(32'h1F80_0004, 1'b0, 1'b0);
    drv0(NONSEQ, 32'h1F80_0004, 1'b0, '0);
    to_mid();
    chk("a_haddr",  S_HADDR,         32'h1F80_0004);
    chk("a_grant",  32'(GRANT),      32'd0);
    chk("a_m0_rdy", 32'(M0_HREADY),  32'd1);
    chk("a_m1_rdy", 32'(M1_HREADY),  32'd1);
    next();
    drv0(IDLE, '0, 1'b0, '0);
    to_mid();
    chk("a_m0_rdy_dp", 32'(M0_HREADY), 32'd1);
    chk("a_m0_rdata",  M0_HRDATA,      32'h1234_5678);
    chk("a_m1_rdata",  M1_HRDATA,      32'h1234_5678);
    next();

    // Simultaneous requests: M1 captured, one switch cycle, then replayed
    exp_addr(32'h0000_0100, 1'b0, 1'b1); exp_data(32'hA0A0_0001);
    exp_addr(32'h0000_0200, 1'b1, 1'b1); exp_data(32'hB0B0_0002);
    drv0(NONSEQ, 32'h0000_0100, 1'b1, '0);
    drv1(NONSEQ, 32'h0000_0200, 1'b1, '0);
    to_mid();
    chk("b_grant0", 32'(GRANT), 32'd0);
    next();
    drv0(IDLE, '0, 1'b0, 32'hA0A0_0001);
    drv1(IDLE, '0, 1'b0, 32'hB0B0_0002);
    to_mid();
    chk("b_m1_rdy_pend", 32'(M1_HREADY), 32'd0);
    chk("b_switch_idle", 32'(S_HTRANS),  32'd0);
    next();
    to_mid();
    chk("b_grant1",       32'(GRANT),     32'd1);
    chk("b_haddr_held",   S_HADDR,        32'h0000_0200);
    chk("b_m1_rdy_addr",  32'(M1_HREADY), 32'd0);
    next();
    to_mid();
    chk("b_m1_rdy_done",  32'(M1_HREADY), 32'd1);
    next();

    // M1 (parked owner) INCR4 write burst while M0 requests
    exp_addr(32'h0000_0300, 1'b1, 1'b1); exp_data(32'h3000_0000);
    exp_addr(32'h0000_0304, 1'b1, 1'b1); exp_data(32'h3000_0001);
    exp_addr(32'h0000_0308, 1'b1, 1'b1); exp_data(32'h3000_0002);
    exp_addr(32'h0000_030C, 1'b1, 1'b1); exp_data(32'h3000_0003);
    exp_addr(32'h0000_0400, 1'b0, 1'b0);
    drv1(NONSEQ, 32'h0000_0300, 1'b1, '0);
    drv0(NONSEQ, 32'h0000_0400, 1'b0, '0);
    to_mid();
    chk("d_grant_b0", 32'(GRANT), 32'd1);
    next();
    drv1(SEQ, 32'h0000_0304, 1'b1, 32'h3000_0000);
    drv0(IDLE, '0, 1'b0, '0);
    to_mid();
    chk("d_m0_rdy_pend", 32'(M0_HREADY), 32'd0);
    chk("d_grant_b1",    32'(GRANT),     32'd1);
    next();
    drv1(SEQ, 32'h0000_0308, 1'b1, 32'h3000_0001);
    to_mid();
    chk("d_grant_b2", 32'(GRANT), 32'd1);
    next();
    drv1(SEQ, 32'h0000_030C, 1'b1, 32'h3000_0002);
    to_mid();
    chk("d_hwdata_b2", S_HWDATA, 32'h3000_0002);
    next();
    drv1(IDLE, '0, 1'b0, 32'h3000_0003);
    to_mid();
    chk("d_switch_idle", 32'(S_HTRANS), 32'd0);
    chk("d_grant_b3",    32'(GRANT),    32'd1);
    next();
    to_mid();
    chk("d_grant_m0",    32'(GRANT),     32'd0);
    chk("d_m0_rdy_addr", 32'(M0_HREADY), 32'd0);
    next();
    S_HRESP = 1'b1;
    to_mid();
    chk("d_m0_resp",   32'(M0_HRESP),  32'd1);
    chk("d_m1_resp",   32'(M1_HRESP),  32'd0);
    chk("d_m0_rdy_dp", 32'(M0_HREADY), 32'd1);
    next();
    S_HRESP = 1'b0;

    // MAX_HOLD preemption: M0 six back-to-back NONSEQ while M1 pends
    exp_addr(32'h0000_0500, 1'b0, 1'b0);
    exp_addr(32'h0000_0504, 1'b0, 1'b0);
    exp_addr(32'h0000_0508, 1'b0, 1'b0);
    exp_addr(32'h0000_050C, 1'b0, 1'b0);
    exp_addr(32'h0000_0600, 1'b1, 1'b1); exp_data(32'hC1C1_0600);
    exp_addr(32'h0000_0510, 1'b0, 1'b0);
    exp_addr(32'h0000_0514, 1'b0, 1'b0);
    drv0(NONSEQ, 32'h0000_0500, 1'b0, '0);
    drv1(NONSEQ, 32'h0000_0600, 1'b1, '0);
    to_mid();
    next();
    drv0(NONSEQ, 32'h0000_0504, 1'b0, '0);
    drv1(IDLE, '0, 1'b0, 32'hC1C1_0600);
    to_mid();
    chk("c_m1_rdy_pend", 32'(M1_HREADY), 32'd0);
    next();
    drv0(NONSEQ, 32'h0000_0508, 1'b0, '0);
    to_mid();
    next();
    drv0(NONSEQ, 32'h0000_050C, 1'b0, '0);
    to_mid();
    next();
    drv0(NONSEQ, 32'h0000_0510, 1'b0, '0);
    to_mid();
    chk("c_switch_idle", 32'(S_HTRANS),  32'd0);
    chk("c_m0_rdy_cap",  32'(M0_HREADY), 32'd1);
    next();
    drv0(NONSEQ, 32'h0000_0514, 1'b0, '0);
    to_mid();
    chk("c_grant_m1",   32'(GRANT),     32'd1);
    chk("c_m0_stalled", 32'(M0_HREADY), 32'd0);
    next();
    to_mid();
    chk("c_switch_back", 32'(S_HTRANS),  32'd0);
    chk("c_m1_rdy_dp",   32'(M1_HREADY), 32'd1);
    next();
    to_mid();
    chk("c_grant_m0",  32'(GRANT), 32'd0);
    chk("c_haddr_5th", S_HADDR,    32'h0000_0510);
    next();
    to_mid();
    chk("c_haddr_6th",   S_HADDR,        32'h0000_0514);
    chk("c_m0_rdy_done", 32'(M0_HREADY), 32'd1);
    next();
    drv0(IDLE, '0, 1'b0, '0);
    to_mid();
    next();

    // Slave wait states during an M1 write data phase, M0 pending
    exp_addr(32'h0000_0700, 1'b1, 1'b1); exp_data(32'hDEAD_BEEF);
    exp_addr(32'h0000_0800, 1'b0, 1'b0);
    drv1(NONSEQ, 32'h0000_0700, 1'b1, '0);
    to_mid();
    chk("e_switch_idle", 32'(S_HTRANS), 32'd0);
    next();
    drv1(IDLE, '0, 1'b0, 32'hDEAD_BEEF);
    drv0(NONSEQ, 32'h0000_0800, 1'b0, '0);
    to_mid();
    chk("e_haddr", S_HADDR,    32'h0000_0700);
    chk("e_grant", 32'(GRANT), 32'd1);
    next();
    drv0(IDLE, '0, 1'b0, '0);
    S_HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_mid();
      chk("e_wait_hwdata", S_HWDATA,       32'hDEAD_BEEF);
      chk("e_wait_m1_rdy", 32'(M1_HREADY), 32'd0);
      chk("e_wait_m0_rdy", 32'(M0_HREADY), 32'd0);
      chk("e_wait_grant",  32'(GRANT),     32'd1);
      next();
    end
    S_HREADY = 1'b1;
    to_mid();
    chk("e_m1_rdy_done", 32'(M1_HREADY), 32'd1);
    chk("e_switch_idle2", 32'(S_HTRANS), 32'd0);
    next();
    to_mid();
    chk("e_grant_m0", 32'(GRANT), 32'd0);
    chk("e_haddr_m0", S_HADDR,    32'h0000_0800);
    next();
    to_mid();
    chk("e_m0_rdy_done", 32'(M0_HREADY), 32'd1);
    next();

    // Reset in the middle of an M1 burst while M0 is pending
    exp_addr(32'h0000_0900, 1'b1, 1'b1); exp_data(32'h9000_0000);
    exp_addr(32'h0000_0904, 1'b1, 1'b1);
    drv1(NONSEQ, 32'h0000_0900, 1'b1, '0);
    to_mid();
    chk("f_switch_idle", 32'(S_HTRANS), 32'd0);
    next();
    drv1(SEQ, 32'h0000_0904, 1'b1, 32'h9000_0000);
    drv0(NONSEQ, 32'h0000_0A00, 1'b0, '0);
    to_mid();
    chk("f_haddr_b0", S_HADDR, 32'h0000_0900);
    next();
    drv0(IDLE, '0, 1'b0, '0);
    to_mid();
    chk("f_haddr_b1",    S_HADDR,        32'h0000_0904);
    chk("f_m1_rdy",      32'(M1_HREADY), 32'd1);
    chk("f_m0_rdy_pend", 32'(M0_HREADY), 32'd0);
    next();
    drv1(SEQ, 32'h0000_0908, 1'b1, 32'h9000_0001);
    HRESETn = 1'b0;
    to_mid();
    next();
    drv1(IDLE, '0, 1'b0, '0);
    to_mid();
    chk("f_rst_htrans", 32'(S_HTRANS),  32'd0);
    chk("f_rst_grant",  32'(GRANT),     32'd0);
    chk("f_rst_m0_rdy", 32'(M0_HREADY), 32'd1);
    chk("f_rst_m1_rdy", 32'(M1_HREADY), 32'd1);
    chk("f_rst_m1_rsp", 32'(M1_HRESP),  32'd0);
    next();
    HRESETn = 1'b1;
    exp_addr(32'h0000_0B00, 1'b1, 1'b0);
    drv1(NONSEQ, 32'h0000_0B00, 1'b0, '0);
    to_mid();
    chk("f_post_idle",  32'(S_HTRANS),  32'd0);
    chk("f_post_grant", 32'(GRANT),     32'd0);
    chk("f_post_m1rdy", 32'(M1_HREADY), 32'd1);
    next();
    drv1(IDLE, '0, 1'b0, '0);
    to_mid();
    chk("f_post_grant1", 32'(GRANT),     32'd1);
    chk("f_post_haddr",  S_HADDR,        32'h0000_0B00);
    chk("f_post_m1_stl", 32'(M1_HREADY), 32'd0);
    next();
    to_mid();
    chk("f_post_m1_done", 32'(M1_HREADY), 32'd1);
    next();
    next();
    next();

    chk("addr_q_drained",  32'(addr_q.size()),  32'd0);
    chk("wdata_q_drained", 32'(wdata_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_arbiter.md
MFP_AHB_ARBITER -- requirements
Module: mfp_ahb_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive NONSEQ transfers the owner may issue while the other master is waiting.
REQ-002 HCLK  in  1  bus clock; all state changes on rising edge.
REQ-003 HRESETn  in  1  synchronous, active-low reset.
REQ-004 M0_HADDR/M0_HTRANS/M0_HWRITE/M0_HSIZE/M0_HWDATA  in  32/2/1/3/32  master 0 (MIPS core) AHB-Lite request.
REQ-005 M0_HRDATA/M0_HREADY/M0_HRESP  out  32/1/1  master 0 response.
REQ-006 M1_HADDR/M1_HTRANS/M1_HWRITE/M1_HSIZE/M1_HWDATA  in  32/2/1/3/32  master 1 (DMA/loader) request.
REQ-007 M1_HRDATA/M1_HREADY/M1_HRESP  out  32/1/1  master 1 response.
REQ-008 S_HADDR/S_HTRANS/S_HWRITE/S_HSIZE/S_HWDATA  out  32/2/1/3/32  shared bus to the slave fabric.
REQ-009 S_HRDATA/S_HREADY/S_HRESP  in  32/1/1  shared slave response.
REQ-010 GRANT  out  1  current address-phase owner (0=M0, 1=M1).

Function
REQ-011 State: owner (1b), data_owner (1b), data_valid (1b), per-master hold register {HADDR,HTRANS,HWRITE,HSIZE} plus pend flag, hold_cnt (3b, saturating).
REQ-012 Effective request of master m = hold register if pend_m else live Mm_* inputs; "requesting" = effective HTRANS[1]=1.
REQ-013 S_HADDR/S_HTRANS/S_HWRITE/S_HSIZE = owner's effective request, except S_HTRANS=IDLE (2'b00) in a switch cycle (REQ-018).
REQ-014 Address accepted at an edge with S_HREADY=1 and S_HTRANS[1]=1: data_owner<=owner, data_valid<=1, pend_owner<=0; edge with S_HREADY=1 and S_HTRANS IDLE: data_valid<=0.
REQ-015 Mm_HREADY = S_HREADY if data_valid and data_owner=m; else 0 if pend_m; else 1.
REQ-016 Capture: Mm requesting live, pend_m=0, Mm_HREADY=1, and its address not accepted this edge -> hold register<=live request, pend_m<=1; Mm_HREADY stays 0 until the held transfer's data phase completes.
REQ-017 S_HWDATA = Mdata_owner_HWDATA; Mm_HRESP = S_HRESP if data_valid and data_owner=m else 0; S_HRDATA broadcast to both Mm_HRDATA.
REQ-018 Switch cycle: S_HREADY=1, owner's effective HTRANS != SEQ, other master requesting (live or pend), and (owner not requesting or hold_cnt>=MAX_HOLD) -> owner<=other, hold_cnt<=0, no address issued that cycle.
REQ-019 SEQ bursts never interrupted; arbitration only at NONSEQ/IDLE boundaries.
REQ-020 hold_cnt increments on each accepted NONSEQ of owner while other is requesting; cleared when other not requesting; saturates at 7.
REQ-021 Neither requesting: owner parks unchanged; S_HTRANS=IDLE.
REQ-022 S_HREADY=0: owner, pend, hold registers, data_owner frozen (captures per REQ-016 still allowed for the non-data-owner).
REQ-023 GRANT = owner (registered, no combinational path from inputs).

Reset
REQ-024 HRESETn=0 at an edge: owner=0, data_owner=0, data_valid=0, pend_0=pend_1=0, hold_cnt=0, hold registers=0; regardless of S_HREADY or burst in progress.
REQ-025 During/after reset: S_HTRANS=IDLE, M0_HREADY=M1_HREADY=1, Mm_HRESP=0, GRANT=0.

Verification
REQ-026 M0 single read 0x1F80_0004 alone, S_HREADY=1 -> S_HADDR=0x1F80_0004 same cycle, M0_HREADY=1 throughout, M1_HREADY=1, GRANT=0.
REQ-027 M0 and M1 NONSEQ same cycle, owner=0, M0 idles next -> M1 captured (pend_1=1, M1_HREADY=0), one IDLE switch cycle, M1 held address on S_HADDR, GRANT=1, M1_HREADY=1 after its data phase.
REQ-028 M0 issues 6 back-to-back NONSEQ while M1 pends, MAX_HOLD=4 -> exactly 4 M0 transfers issued, switch cycle, M1 transfer, then M0 resumes.
REQ-029 M1 INCR4 burst (NONSEQ+3 SEQ) while M0 requests -> no switch until after 4th beat; S_HWDATA follows M1 during all four data phases.
REQ-030 Slave wait states (S_HREADY=0 for 3 cycles) on M1 write 0xDEAD_BEEF -> S_HWDATA held 0xDEAD_BEEF, M1_HREADY=0 for 3 cycles, M0 pend unchanged, GRANT stable.
REQ-031 HRESETn=0 mid-burst with pend_0=1 -> next cycle all state per REQ-024/025; first post-reset request from M1 is granted via one switch cycle.
